// File: rtl/mesi_isc_tb_pkg.sv
// Shared definitions for the MESI ISC bench CPU snoop responder: cbus commands,
// MESI line codes and the responder FSM states.
package mesi_isc_tb_pkg;

  typedef enum logic [2:0] {
    CBUS_NOP      = 3'd0,
    CBUS_WR_SNOOP = 3'd1,
    CBUS_RD_SNOOP = 3'd2,
    CBUS_EN_WR    = 3'd3,
    CBUS_EN_RD    = 3'd4
  } cbus_cmd_e;

  localparam logic [3:0] MESI_ISC_TB_CPU_MESI_M = 4'b1001;
  localparam logic [3:0] MESI_ISC_TB_CPU_MESI_E = 4'b0101;
  localparam logic [3:0] MESI_ISC_TB_CPU_MESI_S = 4'b0011;
  localparam logic [3:0] MESI_ISC_TB_CPU_MESI_I = 4'b0000;

  typedef enum logic [2:0] {
    RSP_IDLE    = 3'd0,
    RSP_LATCH   = 3'd1,
    RSP_WB_REQ  = 3'd2,
    RSP_WB_WAIT = 3'd3,
    RSP_ACK     = 3'd4,
    RSP_HOLD    = 3'd5
  } rsp_state_e;

  function automatic logic mesi_legal(input logic [3:0] code);
    return (code == MESI_ISC_TB_CPU_MESI_M) || (code == MESI_ISC_TB_CPU_MESI_E) ||
           (code == MESI_ISC_TB_CPU_MESI_S) || (code == MESI_ISC_TB_CPU_MESI_I);
  endfunction

endpackage

// File: rtl/mesi_isc_tb_snoop_resp_if.sv
// Coherence-bus and writeback signals of one snoop responder; signal suffixes
// are from the responder's point of view (slave modport).
interface mesi_isc_tb_snoop_resp_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [2:0]        cbus_cmd_i;
  logic [ADDR_W-1:0] cbus_addr_i;
  logic              cbus_ack_o;
  logic              en_wr_o;
  logic              en_rd_o;
  logic              mem_wr_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_ack_i;

  modport slave (
    input  cbus_cmd_i, cbus_addr_i, mem_ack_i,
    output cbus_ack_o, en_wr_o, en_rd_o, mem_wr_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cbus_cmd_i, cbus_addr_i, mem_ack_i,
    input  cbus_ack_o, en_wr_o, en_rd_o, mem_wr_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/mesi_isc_tb_snoop_next_state.sv
// Pure snoop transition: current line state + broadcast command -> new state
// and whether the line must be written back first.
module mesi_isc_tb_snoop_next_state
  import mesi_isc_tb_pkg::*;
(
  input  cbus_cmd_e  cmd_i,
  input  logic [3:0] cur_i,
  output logic [3:0] nxt_o,
  output logic       needs_wb_o
);

  always_comb begin
    nxt_o      = cur_i;
    needs_wb_o = 1'b0;
    case (cmd_i)
      CBUS_WR_SNOOP: begin
        nxt_o      = MESI_ISC_TB_CPU_MESI_I;
        needs_wb_o = (cur_i == MESI_ISC_TB_CPU_MESI_M);
      end
      CBUS_RD_SNOOP: begin
        if ((cur_i == MESI_ISC_TB_CPU_MESI_M) || (cur_i == MESI_ISC_TB_CPU_MESI_E)) begin
          nxt_o      = MESI_ISC_TB_CPU_MESI_S;
          needs_wb_o = (cur_i == MESI_ISC_TB_CPU_MESI_M);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mesi_isc_tb_snoop_resp.sv
// Per-CPU cbus snoop responder: owns cache_state, writes back M lines before acking.
// Optional MESI_ISC_TB_SNOOP_STATS_EN adds saturating snoop/writeback counters.
module mesi_isc_tb_snoop_resp
  import mesi_isc_tb_pkg::*;
#(
  parameter int LINES  = 10,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mesi_isc_tb_snoop_resp_if.slave bus,
  input  logic                  upd_valid_i,
  input  logic [ADDR_W-1:0]     upd_addr_i,
  input  logic [3:0]            upd_state_i,
  output logic                  upd_ready_o,
  input  logic [DATA_W-1:0]     wb_data_i,
  output logic [3:0]            cache_state [LINES-1:0],
  output logic                  err_o
`ifdef MESI_ISC_TB_SNOOP_STATS_EN
  ,
  output logic [15:0]           snoop_cnt_o,
  output logic [15:0]           wb_cnt_o
`endif
);

  rsp_state_e        state_q, state_d;
  cbus_cmd_e         cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              err_q, err_d;

  logic [3:0] cur_state;
  logic [3:0] snp_nxt;
  logic       snp_wb;
  logic       addr_q_ok;
  logic       upd_fire;
  logic       upd_ok;
  logic       commit;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < LINES;
  endfunction

  assign addr_q_ok = addr_in_range(addr_q);
  assign cur_state = addr_q_ok ? cache_state[addr_q] : MESI_ISC_TB_CPU_MESI_I;

  mesi_isc_tb_snoop_next_state u_next (
    .cmd_i      (cmd_q),
    .cur_i      (cur_state),
    .nxt_o      (snp_nxt),
    .needs_wb_o (snp_wb)
  );

  // A broadcast seen in IDLE always wins over a same-cycle local update.
  assign upd_ready_o = (state_q == RSP_IDLE) && (bus.cbus_cmd_i == CBUS_NOP);
  assign upd_fire    = upd_valid_i && upd_ready_o;
  assign upd_ok      = addr_in_range(upd_addr_i) && mesi_legal(upd_state_i);
  assign commit      = (state_q == RSP_ACK) && addr_q_ok;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    mem_wr_d   = mem_wr_q;
    mem_data_d = mem_data_q;
    err_d      = err_q;
    case (state_q)
      RSP_IDLE: begin
        if (bus.cbus_cmd_i != CBUS_NOP) begin
          state_d = RSP_LATCH;
          cmd_d   = cbus_cmd_e'(bus.cbus_cmd_i);
          addr_d  = bus.cbus_addr_i;
          if (!addr_in_range(bus.cbus_addr_i)) err_d = 1'b1;
        end
      end
      RSP_LATCH: begin
        // wb_data_i already reflects the latched address here.
        if (snp_wb) begin
          state_d    = RSP_WB_REQ;
          mem_wr_d   = 1'b1;
          mem_data_d = wb_data_i;
        end else begin
          state_d = RSP_ACK;
        end
      end
      RSP_WB_REQ:  state_d = RSP_WB_WAIT;
      RSP_WB_WAIT: begin
        if (bus.mem_ack_i) begin
          mem_wr_d = 1'b0;
          state_d  = RSP_ACK;
        end
      end
      RSP_ACK:  state_d = RSP_HOLD;
      RSP_HOLD: state_d = RSP_IDLE;
      default:  state_d = RSP_IDLE;
    endcase
    if (upd_fire && !upd_ok) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RSP_IDLE;
      cmd_q      <= CBUS_NOP;
      addr_q     <= '0;
      mem_wr_q   <= 1'b0;
      mem_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      mem_wr_q   <= mem_wr_d;
      mem_data_q <= mem_data_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) cache_state[i] <= MESI_ISC_TB_CPU_MESI_I;
    end else if (commit) begin
      cache_state[addr_q] <= snp_nxt;
    end else if (upd_fire && upd_ok) begin
      cache_state[upd_addr_i] <= upd_state_i;
    end
  end

  assign bus.cbus_ack_o = (state_q == RSP_ACK);
  assign bus.en_wr_o    = (state_q == RSP_ACK) && (cmd_q == CBUS_EN_WR);
  assign bus.en_rd_o    = (state_q == RSP_ACK) && (cmd_q == CBUS_EN_RD);
  assign bus.mem_wr_o   = mem_wr_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = mem_data_q;
  assign err_o          = err_q;

`ifdef MESI_ISC_TB_SNOOP_STATS_EN
  logic [15:0] snoop_cnt_q;
  logic [15:0] wb_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snoop_cnt_q <= '0;
      wb_cnt_q    <= '0;
    end else begin
      if ((state_q == RSP_ACK) && ((cmd_q == CBUS_WR_SNOOP) || (cmd_q == CBUS_RD_SNOOP)))
        snoop_cnt_q <= sat_inc(snoop_cnt_q);
      if ((state_q == RSP_WB_WAIT) && bus.mem_ack_i)
        wb_cnt_q <= sat_inc(wb_cnt_q);
    end
  end

  assign snoop_cnt_o = snoop_cnt_q;
  assign wb_cnt_o    = wb_cnt_q;
`endif

endmodule

// File: tb/tb_mesi_isc_tb_snoop_resp.sv
// Directed bench for the snoop responder: a cycle-level expectation model driven
// by the stimulus tasks, checked against the DUT on every falling edge.
module tb_mesi_isc_tb_snoop_resp;

  localparam int LINES  = 10;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  localparam logic [3:0] ST_M = 4'b1001;
  localparam logic [3:0] ST_E = 4'b0101;
  localparam logic [3:0] ST_S = 4'b0011;
  localparam logic [3:0] ST_I = 4'b0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mesi_isc_tb_snoop_resp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  logic              upd_valid;
  logic [ADDR_W-1:0] upd_addr;
  logic [3:0]        upd_state;
  logic              upd_ready;
  logic [DATA_W-1:0] wb_data;
  logic [3:0]        cache_state [LINES-1:0];
  logic              err;
`ifdef MESI_ISC_TB_SNOOP_STATS_EN
  logic [15:0]       snoop_cnt;
  logic [15:0]       wb_cnt;
`endif

  // CPU data array: each line holds a recognisable pattern.
  assign wb_data = 32'hCAFE_0000 | 32'(bif.mem_addr_o);

  mesi_isc_tb_snoop_resp #(.LINES(LINES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bif),
    .upd_valid_i (upd_valid),
    .upd_addr_i  (upd_addr),
    .upd_state_i (upd_state),
    .upd_ready_o (upd_ready),
    .wb_data_i   (wb_data),
    .cache_state (cache_state),
    .err_o       (err)
`ifdef MESI_ISC_TB_SNOOP_STATS_EN
    ,
    .snoop_cnt_o (snoop_cnt),
    .wb_cnt_o    (wb_cnt)
`endif
  );

  logic [3:0] exp_state [LINES];
  logic       exp_ack, exp_en_wr, exp_en_rd, exp_mem_wr, exp_ready, exp_err;
  logic [3:0] exp_mem_addr;
  int         exp_snoop_cnt, exp_wb_cnt;
  bit         chk_en;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] snoop_next(input logic [2:0] cmd, input logic [3:0] cur);
    if (cmd == 3'd1) return ST_I;
    if (cmd == 3'd2 && (cur == ST_M || cur == ST_E)) return ST_S;
    return cur;
  endfunction

  function automatic bit legal(input logic [3:0] s);
    return s == ST_M || s == ST_E || s == ST_S || s == ST_I;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cbus_ack_o", 32'(bif.cbus_ack_o), 32'(exp_ack));
      check("en_wr_o", 32'(bif.en_wr_o), 32'(exp_en_wr));
      check("en_rd_o", 32'(bif.en_rd_o), 32'(exp_en_rd));
      check("mem_wr_o", 32'(bif.mem_wr_o), 32'(exp_mem_wr));
      check("upd_ready_o", 32'(upd_ready), 32'(exp_ready));
      check("err_o", 32'(err), 32'(exp_err));
      if (exp_mem_wr) begin
        check("mem_addr_o", 32'(bif.mem_addr_o), 32'(exp_mem_addr));
        check("mem_data_o", bif.mem_data_o, 32'hCAFE_0000 | 32'(exp_mem_addr));
      end
      for (int i = 0; i < LINES; i++)
        check($sformatf("cache_state[%0d]", i), 32'(cache_state[i]), 32'(exp_state[i]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) exp_state[i] = ST_I;
    exp_ack = 0; exp_en_wr = 0; exp_en_rd = 0; exp_mem_wr = 0;
    exp_ready = 1; exp_err = 0; exp_mem_addr = '0;
    exp_snoop_cnt = 0; exp_wb_cnt = 0;
  endtask

  // One complete broadcast as the ISC would run it; returns in the IDLE cycle after HOLD.
  task automatic broadcast(input logic [2:0] cmd, input logic [3:0] a, input int mem_lat);
    bit ok;
    bit wb;
    ok = int'(a) < LINES;
    wb = ok && (cmd == 3'd1 || cmd == 3'd2) && exp_state[a] == ST_M;
    bif.cbus_cmd_i = cmd; bif.cbus_addr_i = a; exp_ready = 0;
    step();
    if (!ok) exp_err = 1;
    if (wb) begin
      step();
      exp_mem_wr = 1; exp_mem_addr = a;
      step();
      repeat (mem_lat) step();
      bif.mem_ack_i = 1;
      step();
      bif.mem_ack_i = 0; exp_mem_wr = 0; exp_wb_cnt++;
    end else begin
      step();
    end
    exp_ack = 1; exp_en_wr = (cmd == 3'd3); exp_en_rd = (cmd == 3'd4);
    step();
    exp_ack = 0; exp_en_wr = 0; exp_en_rd = 0; bif.cbus_cmd_i = 3'd0;
    if (ok) exp_state[a] = snoop_next(cmd, exp_state[a]);
    if (cmd == 3'd1 || cmd == 3'd2) exp_snoop_cnt++;
    step();
    exp_ready = 1;
  endtask

  task automatic upd(input logic [3:0] a, input logic [3:0] s);
    upd_valid = 1; upd_addr = a; upd_state = s;
    step();
    upd_valid = 0;
    if (int'(a) < LINES && legal(s)) exp_state[a] = s;
    else exp_err = 1;
  endtask

  initial begin
    chk_en = 0;
    rst = 1;
    upd_valid = 0; upd_addr = '0; upd_state = '0;
    bif.cbus_cmd_i = 3'd0; bif.cbus_addr_i = '0; bif.mem_ack_i = 0;
    clear_model();
    step();
    chk_en = 1;
    step();
    check("reset err_o", 32'(err), 32'd0);
    check("reset line0", 32'(cache_state[0]), 32'h0);
    rst = 0;
    step();

    // 1: M line read-snooped -> writeback then S
    upd(4'd3, ST_M);
    broadcast(3'd2, 4'd3, 2);
    check("t1 line3 S", 32'(cache_state[3]), 32'h3);

    // 2: E line write-snooped -> I without writeback; also M line write-snooped
    upd(4'd5, ST_E);
    broadcast(3'd1, 4'd5, 0);
    check("t2 line5 I", 32'(cache_state[5]), 32'h0);
    upd(4'd8, ST_M);
    broadcast(3'd1, 4'd8, 0);
    broadcast(3'd2, 4'd5, 0);

    // 3: enables pulse with the ack, no state change
    upd(4'd2, ST_S);
    broadcast(3'd3, 4'd2, 0);
    broadcast(3'd4, 4'd2, 0);
    check("t3 line2 S", 32'(cache_state[2]), 32'h3);

    // 4: simultaneous update and snoop: snoop E->S first, then the update lands
    upd(4'd7, ST_E);
    upd_valid = 1; upd_addr = 4'd7; upd_state = ST_M;
    broadcast(3'd2, 4'd7, 0);
    check("t4 line7 S before upd", 32'(cache_state[7]), 32'h3);
    upd(4'd7, ST_M);
    check("t4 line7 M", 32'(cache_state[7]), 32'h9);

    // 5: out-of-range broadcast, err sticky
    broadcast(3'd1, 4'd12, 0);
    check("t5 err set", 32'(err), 32'd1);
    broadcast(3'd2, 4'd7, 1);
    check("t5 err sticky", 32'(err), 32'd1);

    // 6: reset in the middle of a writeback wait
    upd(4'd6, ST_M);
    bif.cbus_cmd_i = 3'd2; bif.cbus_addr_i = 4'd6; exp_ready = 0;
    step();
    step();
    exp_mem_wr = 1; exp_mem_addr = 4'd6;
    step();
    step();
    rst = 1; bif.cbus_cmd_i = 3'd0;
    #1;
    check("t6 mem_wr async drop", 32'(bif.mem_wr_o), 32'd0);
    check("t6 line6 I", 32'(cache_state[6]), 32'h0);
    clear_model();
    step();
    step();
    rst = 0;
    repeat (4) step();

    // illegal update code and out-of-range update address
    upd(4'd1, 4'b1111);
    upd(4'd11, ST_M);
    upd(4'd9, ST_M);
    broadcast(3'd1, 4'd9, 3);
    check("final line9 I", 32'(cache_state[9]), 32'h0);

`ifdef MESI_ISC_TB_SNOOP_STATS_EN
    check("snoop_cnt_o", 32'(snoop_cnt), 32'(exp_snoop_cnt));
    check("wb_cnt_o", 32'(wb_cnt), 32'(exp_wb_cnt));
`endif
    step();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
